// File: rtl/cla_pkg.sv
// Shared types for the multi-word carry look-ahead adder: word type, word width and packet FSM states.
package cla_pkg;
  localparam int CLA_WORD_W = 16;

  typedef logic [15:0] cla_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cla_mw_state_t;
endpackage

// File: rtl/carry_look_ahead_16bit.sv
// Combinational 16-bit adder: four 4-bit look-ahead groups with a look-ahead carry between groups.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Group carries are resolved from group generate/propagate, not by rippling through bits.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  always_comb begin
    logic [3:0] c;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      c[0] = gc[k];
      c[1] = g[4*k]   | (p[4*k]   & c[0]);
      c[2] = g[4*k+1] | (p[4*k+1] & c[1]);
      c[3] = g[4*k+2] | (p[4*k+2] & c[2]);
      sum[4*k +: 4] = p[4*k +: 4] ^ c;
    end
  end

  assign cout = gc[4];
endmodule

// File: rtl/cla_multiword_adder.sv
// Streaming multi-word adder: one 16-bit word pair per beat, LS word first, carry chained across beats.
// Optional signed-overflow output out_ovf is built when CLA_MULTIWORD_OVF_EN is defined.
module cla_multiword_adder
  import cla_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_beats,
  output logic             proto_err
`ifdef CLA_MULTIWORD_OVF_EN
  ,
  output logic             out_ovf
`endif
);
  // Handshake: a beat moves when valid && ready; in_ready = !out_valid || out_ready.

  if (WORD_W != CLA_WORD_W) begin : g_bad_word_w
    $error("cla_multiword_adder: WORD_W must be 16");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  cla_mw_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, beat_num;
  logic             carry_q;
  logic             accept;
  logic             cla_cin, cla_cout;
  logic             eff_last, viol;
  cla_word_t        cla_sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  carry_look_ahead_16bit u_cla (
    .a    (in_a),
    .b    (in_b),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // A beat without first in IDLE restarts the packet with carry-in 0.
  always_comb begin
    cla_cin  = carry_q;
    beat_num = count_q + CNT_W'(1);
    viol     = 1'b0;
    eff_last = in_last;
    state_d  = state_q;
    count_d  = count_q;
    if (in_first) begin
      cla_cin  = cin;
      beat_num = CNT_W'(1);
      viol     = (state_q == BUSY);
    end else if (state_q == IDLE) begin
      cla_cin  = 1'b0;
      beat_num = CNT_W'(1);
      viol     = 1'b1;
    end
    if (!in_last && beat_num == MAX_CNT) begin
      eff_last = 1'b1;
      viol     = 1'b1;
    end
    if (eff_last) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      state_d = BUSY;
      count_d = beat_num;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_beats <= '0;
      proto_err <= 1'b0;
      carry_q   <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
    end else begin
      proto_err <= accept && viol;
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= cla_sum;
        out_last  <= eff_last;
        out_cout  <= eff_last & cla_cout;
        out_beats <= eff_last ? beat_num : '0;
        carry_q   <= cla_cout;
        state_q   <= state_d;
        count_q   <= count_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CLA_MULTIWORD_OVF_EN
  // Carry into bit 15 recovered as a^b^sum, compared with the carry out of bit 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (accept) begin
      out_ovf <= eff_last & ((in_a[15] ^ in_b[15] ^ cla_sum[15]) ^ cla_cout);
    end
  end
`endif
endmodule

// File: doc/cla_multiword_adder.md
Name: cla_multiword_adder

Overview:
- Streaming multi-precision adder built around the existing 16-bit carry look-ahead adder (`carry_look_ahead_16bit`).
- Accepts operands as packets of 16-bit word pairs, least-significant word first, one beat per cycle. Each word pair goes through the CLA with the carry chained across beats in a register.
- Emits registered sum words plus the final carry-out.
- Sits between the operand sequencer upstream and result writeback downstream. Valid/ready on both sides.

Parameters:
- WORD_W, 16, operand word width; fixed at 16 to match the CLA. Any other value is an elaboration error.
- MAX_WORDS, 8, maximum beats per packet (operand width = WORD_W*MAX_WORDS).
- CNT_W, $clog2(MAX_WORDS+1), width of the beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- in_first  in  1  first (least-significant) beat of packet.
- in_last  in  1  last (most-significant) beat of packet.
- cin  in  1  packet carry-in; sampled only on an accepted first beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_sum  out  16  sum word.
- out_last  out  1  marks the final sum word.
- out_cout  out  1  packet carry-out; meaningful only when out_last=1, otherwise 0.
- out_beats  out  CNT_W  beat count of the packet; meaningful only when out_last=1.
- proto_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- in_ready = !out_valid || out_ready: a single output register, full throughput, no skid buffer.
- CLA inputs:
  - a = in_a, b = in_b.
  - carry-in = cin if in_first, else the carry register.
- Latency: 1 cycle from accept to out_valid.
- States:
  - IDLE, meaning no packet open.
  - BUSY, meaning a packet is open and the carry register is live.
- Transitions on accept:
  - first && last: single-word packet; state stays IDLE.
  - first && !last: go to BUSY; count = 1.
  - !first && last in BUSY: go to IDLE.
  - !first && !last in BUSY: stay in BUSY; count += 1.
- On every accept:
  - carry register <= CLA cout.
  - out_sum <= CLA sum; out_last <= in_last.
  - out_cout <= in_last ? CLA cout : 0.
  - out_beats <= count+1 on the last beat.
- Violations (each pulses proto_err for one cycle, registered one cycle after the accept):
  - !first in IDLE: the beat is processed as a first beat with carry-in 0.
  - first in BUSY: the open packet is abandoned, no out_last is emitted for it, and the new packet starts normally.
  - Beat count reaching MAX_WORDS without last: that beat is forced to act as last (out_last=1, state goes to IDLE).
- Backpressure: while out_valid && !out_ready, all output registers, the carry register, state and count hold.
- Reset (any cycle, including mid-packet):
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, out_beats=0, proto_err=0.
  - carry register=0, state=IDLE, count=0.
  - Any beat presented in the reset cycle is dropped.
- Wrap-around: a sum with full carry (for example all-ones + 1) propagates the carry through every word. The final carry appears only on out_cout.

Optional Feature:
- Macro CLA_MULTIWORD_OVF_EN.
- Defined:
  - adds port out_ovf (out, 1).
  - On the last beat, out_ovf = signed two's-complement overflow of the whole packet: carry into the MSB XOR carry out of the MSB, computed from the MSB word via (a[15]^b[15]^sum[15]) ^ cout.
  - out_ovf is 0 on non-last beats and 0 at reset.
- Undefined: no out_ovf port and no logic.

Decomposition:
- Package cla_pkg:
  - localparam CLA_WORD_W=16.
  - typedef logic [15:0] cla_word_t.
  - enum typedef cla_mw_state_t {IDLE, BUSY}.
- Sub-module: instantiate the existing carry_look_ahead_16bit for the combinational add. No new sub-module.

Test Plan:
- Single-word packet: a=2, b=3, cin=1, first=last=1 -> out_sum=6, out_cout=0, out_last=1, out_beats=1, one cycle after accept.
- Two-word carry chain: beat0 a=16'hFFFF, b=16'h0001, cin=0; beat1 a=0, b=0 -> sums 16'h0000 then 16'h0001, out_cout=0, out_beats=2.
- Full wrap-around: 4 beats of a=16'hFFFF, b=0, cin=1 -> four sums of 16'h0000, out_cout=1 on the last beat.
- Backpressure: hold out_ready=0 for 3 cycles mid-packet -> in_ready=0, out_sum stable, no beat lost; the result matches the reference sum once released.
- Protocol errors:
  - !first beat in IDLE -> proto_err pulse, processed with carry-in 0.
  - 9-beat packet with MAX_WORDS=8 -> proto_err pulse, out_last forced on beat 8.
- Reset mid-packet: assert rst after beat 1 of 3 -> out_valid=0 next cycle; a new packet a=18, b=18, cin=0 -> out_sum=36 (no stale carry).
